// File: rtl/fifo_symbol_packer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_symbol_packer_pkg
//
// Purpose: constants and types shared by the symbol packer and the FIFO
// wrapper around it. It holds the default symbol width and the symbol count
// per word, the two-state FSM encoding, and a helper that sizes the slot
// counter.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package fifo_symbol_packer_pkg;

  localparam int DEFAULT_WIDTH = 3;
  localparam int DEFAULT_SYMS  = 3;

  // Packer FSM: collect symbols in FILL, then present the word in HOLD.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

  // Plain vector aliases of the enum values for legacy code that stores the
  // state in a bare logic vector.
  localparam logic [0:0] ST_FILL = FILL;
  localparam logic [0:0] ST_HOLD = HOLD;

  // Slot counter width. The result is never less than 1, so that the
  // counter always has at least one bit.
  function automatic int cnt_width(input int syms);
    return (syms <= 2) ? 1 : $clog2(syms);
  endfunction

endpackage

// File: rtl/fifo_symbol_packer.sv
// ---------------------------------------------------------------------------
// fifo_symbol_packer
//
// Purpose: pops WIDTH-bit symbols from a show-ahead FIFO and packs SYMS of
// them into a single output word. The first symbol popped lands in the LSBs.
// A complete word is held with out_valid=1 until downstream accepts it with
// out_ready. While a word is held, no symbols are popped.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   empty      in   FIFO empty flag
//   rdata      in   FIFO head symbol (valid whenever empty=0)
//   re         out  FIFO pop strobe (combinational)
//   flush      in   discard the partially assembled word
//   out_data   out  assembled word, WIDTH*SYMS bits
//   out_valid  out  out_data holds a complete word
//   out_ready  in   downstream accepts the word
//   out_par    out  XOR of all out_data bits (only when
//                   FIFO_SYMBOL_PACKER_PARITY_EN is defined)
//
// Configuration macro: FIFO_SYMBOL_PACKER_PARITY_EN
// ---------------------------------------------------------------------------
module fifo_symbol_packer
  import fifo_symbol_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SYMS  = DEFAULT_SYMS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  re,
  input  logic                  flush,
  output logic [WIDTH*SYMS-1:0] out_data,
  output logic                  out_valid,
`ifdef FIFO_SYMBOL_PACKER_PARITY_EN
  output logic                  out_par,
`endif
  input  logic                  out_ready
);

  localparam int                CNT_W     = cnt_width(SYMS);
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(SYMS - 1);

  logic [0:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [WIDTH*SYMS-1:0] next_word;

  // Returns the word with one slot replaced. Slots that have not been
  // filled yet keep stale contents. This is harmless, because out_valid is
  // low until every slot has been written.
  function automatic logic [WIDTH*SYMS-1:0] insert_sym(
    input logic [WIDTH*SYMS-1:0] word,
    input logic [CNT_W-1:0]      slot,
    input logic [WIDTH-1:0]      sym
  );
    logic [WIDTH*SYMS-1:0] w;
    w = word;
    w[slot*WIDTH +: WIDTH] = sym;
    return w;
  endfunction

  assign next_word = insert_sym(out_data, cnt, rdata);

  // The word is valid exactly while the FSM is in HOLD. Because out_valid is
  // a pure function of registered state, it never depends combinationally
  // on out_ready.
  assign out_valid = (state == ST_HOLD);

  // Pop strobe. Popping is allowed only while filling, with data present and
  // no flush. Gating with rst keeps re low for the whole reset pulse, even
  // before the asynchronous clear has taken effect.
  always_comb begin
    re = 1'b0;
    if (!rst && (state == ST_FILL) && !empty && !flush) begin
      re = 1'b1;
    end
  end

  // FSM, slot counter and word register.
  // In FILL: each pop writes one slot. The pop that writes the last slot
  // moves the FSM to HOLD. A flush only rewinds the counter, because the
  // stale slot contents are never exposed. An empty FIFO stalls the FSM and
  // the counter keeps its value.
  // In HOLD: the FSM waits for out_ready and ignores flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      cnt      <= '0;
      out_data <= '0;
`ifdef FIFO_SYMBOL_PACKER_PARITY_EN
      out_par  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FILL: begin
          if (flush) begin
            cnt <= '0;
          end else if (re) begin
            out_data <= next_word;
`ifdef FIFO_SYMBOL_PACKER_PARITY_EN
            out_par  <= ^next_word;
`endif
            if (cnt == LAST_SLOT) begin
              cnt   <= '0;
              state <= ST_HOLD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (out_ready) begin
            state <= ST_FILL;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_symbol_packer.md
FIFO_SYMBOL_PACKER -- requirements
Module: fifo_symbol_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 3, the symbol width in bits, matching the FIFO data width.
REQ-002 SHALL have parameter SYMS, default 3, the number of symbols per output word; legal range 2..8.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 SHALL have port empty, input, 1 bit, FIFO empty flag.
REQ-006 SHALL have port rdata, input, WIDTH bits, FIFO head symbol, show-ahead: valid whenever empty=0.
REQ-007 SHALL have port re, output, 1 bit, FIFO pop strobe; one symbol is consumed per clk edge with re=1.
REQ-008 SHALL have port flush, input, 1 bit, discards any partially assembled word.
REQ-009 SHALL have port out_data, output, WIDTH*SYMS bits, the assembled word.
REQ-010 SHALL have port out_valid, output, 1 bit, out_data holds a complete word.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts the word.

Function
REQ-012 SHALL implement a two-state FSM: FILL, then HOLD.
REQ-013 In FILL, re SHALL equal !empty && !flush; combinational, no registered delay.
REQ-014 re SHALL never be 1 while empty=1 or while in HOLD.
REQ-015 On a pop, rdata SHALL be written into slot cnt, bits [cnt*WIDTH +: WIDTH]; the first-popped symbol goes in the LSBs; cnt then increments.
REQ-016 When the pop fills slot SYMS-1, FSM SHALL enter HOLD, cnt SHALL clear, and out_valid SHALL be 1 on the next cycle.
REQ-017 Latency: out_valid SHALL rise exactly 1 cycle after the final symbol's pop edge; minimum word period is SYMS+1 cycles.
REQ-018 In HOLD, out_valid SHALL be 1 and out_data SHALL be stable until the cycle with out_ready=1, after which FSM returns to FILL.
REQ-019 out_valid SHALL not depend combinationally on out_ready; out_ready while in FILL is ignored.
REQ-020 flush in FILL SHALL clear cnt, suppress re that cycle, and retain no partial symbols.
REQ-021 flush in HOLD SHALL be ignored, because the word is already complete.
REQ-022 FIFO going empty mid-word SHALL stall assembly with cnt retained; no timeout applies.
REQ-023 Unfilled slot contents SHALL be don't-care internally but SHALL never be visible, since out_valid=0 then.

Reset
REQ-024 rst=1 SHALL immediately force FSM=FILL, cnt=0, out_data=0, and out_valid=0; re SHALL be 0 while rst=1.
REQ-025 Reset mid-word or in HOLD SHALL discard all held data; symbols already popped are lost by design.

Configuration
REQ-026 Macro FIFO_SYMBOL_PACKER_PARITY_EN: when defined, SHALL add output out_par, 1 bit, registered alongside out_data, equal to the XOR of all out_data bits, 0 under reset.
REQ-027 Without the macro, SHALL have no out_par port and no parity logic; all other behaviour is identical.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (FILL, HOLD) and the default WIDTH/SYMS constants, shared with the FIFO wrapper.
REQ-029 cnt width SHALL be $clog2(SYMS) from the package helper; no sub-module is required.
REQ-030 The block SHALL be flat, with a single always_ff for state and data and one always_comb for re.

Verification
REQ-031 Pack: empty=0, rdata 1,2,3 on consecutive pops, out_ready=1 -> out_data=9'h0D1 with out_valid for 1 cycle, 1 cycle after the 3rd pop; out_par=0 with the macro defined.
REQ-032 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_data stable, re=0 throughout, FIFO unpopped.
REQ-033 Underflow: empty=1 after 2 pops for 4 cycles -> re=0, cnt held; next symbol completes the word correctly.
REQ-034 Flush: flush after 2 pops -> next 3 pops (4,5,6) yield out_data=9'h1AC only.
REQ-035 Reset: rst pulse mid-cycle while in HOLD -> out_valid=0 and re=0 immediately, without waiting for a clk edge; packing restarts at slot 0.
